seg7_time_scan: RTL and testbench

// - Display driver downstream of the output selector: takes the 12-bit time word
//   {min[11:6], sec[5:0]} and drives a 4-digit multiplexed seven-segment display as MM:SS.
// - Does per-field saturation, binary-to-BCD, segment encoding and time-multiplexed scanning.
// - Samples the input once per scan frame, so all four digits of a frame come from one value.

---
 rtl/seg7_time_scan.sv | 173 +++++++++++++++++
 tb/tb_seg7_time_scan.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/seg7_time_scan.sv
//------------------------------------------------------------------------------
// Module   : seg7_time_scan
// Brief    : MM:SS four-digit multiplexed seven-segment driver with per-frame
//            input snapshot. Optional macro SEG7_LZ_BLANK_EN blanks min tens < 10.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module seg7_time_scan #(
    parameter int REFRESH_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] time_in,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp,
    output logic        frame_tick
);

    localparam int c_PRESC_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_TC  = c_PRESC_W'(REFRESH_DIV - 1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_ONE = c_PRESC_W'(1);
    localparam logic [5:0]           c_FIELD_MAX = 6'd59;

    typedef enum logic [1:0] {
        DIG_SEC_ONES = 2'd0,
        DIG_SEC_TENS = 2'd1,
        DIG_MIN_ONES = 2'd2,
        DIG_MIN_TENS = 2'd3
    } digit_t;

    logic [c_PRESC_W-1:0] r_presc;
    digit_t               r_idx;
    logic [11:0]          r_snap;

    logic                 w_presc_tc;
    digit_t               w_idx_next;
    logic [5:0]           w_sec_sat;
    logic [5:0]           w_min_sat;
    logic [7:0]           w_sec_bcd;
    logic [7:0]           w_min_bcd;
    logic [3:0]           w_digit;
    logic [6:0]           w_seg_next;
    logic [3:0]           w_an_next;
    logic                 w_dp_next;

    function automatic logic [5:0] sat_field(input logic [5:0] v);
        return (v > c_FIELD_MAX) ? c_FIELD_MAX : v;
    endfunction

    // Compare/subtract chain valid for 0..59; returns {tens, ones}.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [5:0] rem;
        logic [3:0] tens;
        rem  = v;
        tens = 4'd0;
        if (rem >= 6'd40) begin
            rem  = rem - 6'd40;
            tens = tens + 4'd4;
        end
        if (rem >= 6'd20) begin
            rem  = rem - 6'd20;
            tens = tens + 4'd2;
        end
        if (rem >= 6'd10) begin
            rem  = rem - 6'd10;
            tens = tens + 4'd1;
        end
        return {tens, rem[3:0]};
    endfunction

    function automatic logic [6:0] encode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    assign w_presc_tc = (r_presc == c_PRESC_TC);

    always_comb begin
        w_idx_next = DIG_SEC_ONES;
        case (r_idx)
            DIG_SEC_ONES: w_idx_next = DIG_SEC_TENS;
            DIG_SEC_TENS: w_idx_next = DIG_MIN_ONES;
            DIG_MIN_ONES: w_idx_next = DIG_MIN_TENS;
            DIG_MIN_TENS: w_idx_next = DIG_SEC_ONES;
            default:      w_idx_next = DIG_SEC_ONES;
        endcase
    end

    always_comb begin
        w_sec_sat = sat_field(r_snap[5:0]);
        w_min_sat = sat_field(r_snap[11:6]);
        w_sec_bcd = to_bcd(w_sec_sat);
        w_min_bcd = to_bcd(w_min_sat);
        w_digit   = 4'd0;
        w_dp_next = 1'b0;
        w_an_next = 4'b0000;
        case (r_idx)
            DIG_SEC_ONES: begin
                w_digit   = w_sec_bcd[3:0];
                w_an_next = 4'b0001;
            end
            DIG_SEC_TENS: begin
                w_digit   = w_sec_bcd[7:4];
                w_an_next = 4'b0010;
            end
            DIG_MIN_ONES: begin
                w_digit   = w_min_bcd[3:0];
                w_an_next = 4'b0100;
                w_dp_next = 1'b1;
            end
            DIG_MIN_TENS: begin
                w_digit   = w_min_bcd[7:4];
                w_an_next = 4'b1000;
            end
            default: begin
                w_digit   = 4'd0;
                w_an_next = 4'b0000;
            end
        endcase
        w_seg_next = encode(w_digit);
`ifdef SEG7_LZ_BLANK_EN
        // Anode still strobes so the scan duty cycle stays uniform.
        if ((r_idx == DIG_MIN_TENS) && (w_min_sat < 6'd10)) begin
            w_seg_next = 7'h00;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc    <= '0;
            r_idx      <= DIG_SEC_ONES;
            r_snap     <= 12'h000;
            seg        <= 7'h00;
            an         <= 4'b0000;
            dp         <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= 1'b0;
            if (w_presc_tc) begin
                r_presc <= '0;
                r_idx   <= w_idx_next;
                if (r_idx == DIG_MIN_TENS) begin
                    r_snap     <= time_in;
                    frame_tick <= 1'b1;
                end
            end else begin
                r_presc <= r_presc + c_PRESC_ONE;
            end
            seg <= w_seg_next;
            an  <= w_an_next;
            dp  <= w_dp_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seg7_time_scan.sv
//------------------------------------------------------------------------------
// Module   : tb_seg7_time_scan
// Brief    : Self-checking bench for seg7_time_scan against a cycle-count model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seg7_time_scan;

    localparam int N     = 4;
    localparam int FRAME = 4 * N;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] time_in = 12'h000;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        dp;
    logic        frame_tick;

    int vectors    = 0;
    int miscompares = 0;

    // Model state: m = clock edges since reset was last released, snap_m = shown value.
    int          m = 0;
    logic [11:0] snap_m = 12'h000;
    logic [6:0]  segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    seg7_time_scan #(.REFRESH_DIV(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .time_in    (time_in),
        .seg        (seg),
        .an         (an),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, m);
        end
    endtask

    task automatic step();
        logic [6:0] e_seg;
        logic [3:0] e_an;
        logic       e_dp;
        logic       e_ft;
        int         idx;
        int         s;
        int         mn;
        int         d;
        if (rst) begin
            e_seg  = 7'h00;
            e_an   = 4'b0000;
            e_dp   = 1'b0;
            e_ft   = 1'b0;
            m      = 0;
            snap_m = 12'h000;
        end else begin
            idx = (m / N) % 4;
            s   = int'(snap_m[5:0]);
            mn  = int'(snap_m[11:6]);
            if (s > 59)  s = 59;
            if (mn > 59) mn = 59;
            case (idx)
                0:       d = s % 10;
                1:       d = s / 10;
                2:       d = mn % 10;
                default: d = mn / 10;
            endcase
            e_seg = segtab[d];
`ifdef SEG7_LZ_BLANK_EN
            if (idx == 3 && mn < 10) e_seg = 7'h00;
`endif
            e_an = 4'b0001 << idx;
            e_dp = (idx == 2);
            e_ft = ((m % FRAME) == FRAME - 1);
            if (e_ft) snap_m = time_in;
            m++;
        end
        @(posedge clk);
        #1;
        chk("seg", seg, e_seg);
        chk("an", {3'b000, an}, {3'b000, e_an});
        chk("dp", {6'b0, dp}, {6'b0, e_dp});
        chk("frame_tick", {6'b0, frame_tick}, {6'b0, e_ft});
    endtask

    task automatic run_to(input int pos);
        for (int k = 0; k < 2 * FRAME && (m % FRAME) != pos; k++) step();
    endtask

    initial begin
        // Reset held, then first frame 00:00 while 12:34 waits for the snapshot.
        rst = 1'b1;
        time_in = 12'h000;
        repeat (3) step();
        rst = 1'b0;
        time_in = {6'd12, 6'd34};
        repeat (FRAME + 2) step();
        run_to(0);
        repeat (FRAME) step();

        // Saturation of both fields.
        time_in = {6'd63, 6'd60};
        run_to(FRAME - 1);
        repeat (FRAME + 1) step();

        // Input changes mid-frame must not leak into the frame in progress.
        time_in = {6'd12, 6'd34};
        run_to(FRAME - 1);
        step();
        run_to(N);
        time_in = {6'd45, 6'd7};
        run_to(FRAME - 1);
        repeat (FRAME + 1) step();

        // One-cycle reset at the min-ones digit.
        run_to(2 * N);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (FRAME + 4) step();

        // Minutes below ten: leading-zero slot.
        time_in = {6'd5, 6'd7};
        run_to(FRAME - 1);
        repeat (FRAME + 1) step();

        // Random inputs with sporadic resets.
        repeat (300) begin
            time_in = 12'($urandom);
            rst     = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;
        repeat (FRAME + 4) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
